// File: rtl/ringbuffer_counted_if.sv
// Writer/reader/status bundle for ringbuffer_counted; master drives requests, slave is the buffer.
// Clock and reset stay outside as plain ports on the buffer.
interface ringbuffer_counted_if #(
    parameter int AW = 8,
    parameter int DW = 48,
    parameter int CW = 16
);
    logic          flush;
    logic          write_enable;
    logic [DW-1:0] write_data;
    logic          read_enable;
    logic [DW-1:0] read_data;
    logic          read_valid;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [AW:0]   level;
    logic          overflow;
    logic [CW-1:0] drop_count;
    logic          clear_overflow;

    modport master (
        output flush, write_enable, write_data, read_enable, clear_overflow,
        input  read_data, read_valid, empty, full, almost_full, level, overflow, drop_count
    );

    modport slave (
        input  flush, write_enable, write_data, read_enable, clear_overflow,
        output read_data, read_valid, empty, full, almost_full, level, overflow, drop_count
    );
endinterface

// File: rtl/ringbuffer_counted.sv
// Counted ring buffer (all 2^AW slots usable), falling-edge clocked, read latency 1 with read_valid.
// No backpressure: writes while full (without a same-edge read) are dropped and counted.
module ringbuffer_counted #(
    parameter int AW       = 8,
    parameter int DW       = 48,
    parameter int CW       = 16,
    parameter int AFULL_TH = 2**AW - 4
) (
    input logic             clock,
    input logic             reset,
    ringbuffer_counted_if.slave bus
);
    localparam logic [AW:0]   LEVEL_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   LEVEL_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] DROP_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic [DW-1:0] rd_dat_q;
    logic          rd_vld_q;
    logic          overflow_q;
    logic [CW-1:0] drop_q;

    logic is_empty;
    logic is_full;
    logic rd_acc;
    logic wr_acc;
    logic drop;

    assign is_empty = (level_q == '0);
    assign is_full  = (level_q == LEVEL_MAX);

    // A read at full frees the slot the same edge, so the write is still taken.
    assign rd_acc = bus.read_enable  && !is_empty && !bus.flush;
    assign wr_acc = bus.write_enable && !bus.flush && (!is_full || rd_acc);
    assign drop   = bus.write_enable && !bus.flush && is_full && !rd_acc;

    // Array kept free of reset so it maps onto block RAM.
    always_ff @(negedge clock) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.write_data;
        end
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            rd_dat_q <= '0;
        end else if (rd_acc) begin
            rd_dat_q <= mem[rd_ptr];
        end
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            rd_vld_q <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level_q <= level_q + LEVEL_ONE;
                2'b01:   level_q <= level_q - LEVEL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // A drop on the clearing edge is kept, so the event is never lost.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (bus.clear_overflow) begin
            overflow_q <= drop;
            drop_q     <= drop ? DROP_ONE : '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_q != {CW{1'b1}}) begin
                drop_q <= drop_q + DROP_ONE;
            end
        end
    end

    assign bus.read_data   = rd_dat_q;
    assign bus.read_valid  = rd_vld_q;
    assign bus.empty       = is_empty;
    assign bus.full        = is_full;
    assign bus.almost_full = (int'(level_q) >= AFULL_TH);
    assign bus.level       = level_q;
    assign bus.overflow    = overflow_q;
    assign bus.drop_count  = drop_q;
endmodule

// File: tb/tb_ringbuffer_counted.sv
// Scoreboard bench for ringbuffer_counted (AW=3, DW=8, CW=4, AFULL_TH=4) against a queue-based model.
module tb_ringbuffer_counted;
    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int CW    = 4;
    localparam int AFTH  = 4;
    localparam int DEPTH = 8;
    localparam int DMAX  = 15;

    logic clock = 1'b0;
    logic reset = 1'b0;

    ringbuffer_counted_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

    ringbuffer_counted #(.AW(AW), .DW(DW), .CW(CW), .AFULL_TH(AFTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: stored words, expected read-out words, sticky drop state.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] sb[$];
    bit            exp_rv  = 1'b0;
    logic [DW-1:0] last_rd = '0;
    bit            m_ovf   = 1'b0;
    int            m_dc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        exp_rv  = 1'b0;
        last_rd = '0;
        m_ovf   = 1'b0;
        m_dc    = 0;
    endtask

    task automatic check_status();
        chk("level", int'(bus.level), mq.size());
        chk("empty", int'(bus.empty), int'(mq.size() == 0));
        chk("full", int'(bus.full), int'(mq.size() == DEPTH));
        chk("almost_full", int'(bus.almost_full), int'(mq.size() >= AFTH));
        chk("overflow", int'(bus.overflow), int'(m_ovf));
        chk("drop_count", int'(bus.drop_count), m_dc);
    endtask

    // Monitor: DUT state settles on the falling edge, sampled on the rising edge.
    always @(posedge clock) begin
        check_status();
        chk("read_valid", int'(bus.read_valid), int'(exp_rv));
        if (exp_rv) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: read_valid with no expected word at %0t", $time);
            end else begin
                last_rd = sb.pop_front();
            end
        end
        chk("read_data", int'(bus.read_data), int'(last_rd));
    end

    task automatic step(input bit we, input logic [DW-1:0] wd, input bit re,
                        input bit fl, input bit clr);
        bit racc;
        bit wacc;
        bit drp;
        @(posedge clock);
        #1;
        bus.write_enable   = we;
        bus.write_data     = wd;
        bus.read_enable    = re;
        bus.flush          = fl;
        bus.clear_overflow = clr;
        if (fl) begin
            mq.delete();
            exp_rv = 1'b0;
            drp    = 1'b0;
        end else begin
            racc = re && (mq.size() > 0);
            wacc = we && ((mq.size() < DEPTH) || racc);
            drp  = we && !wacc;
            if (racc) sb.push_back(mq.pop_front());
            if (wacc) mq.push_back(wd);
            exp_rv = racc;
        end
        if (clr) begin
            m_ovf = drp;
            m_dc  = drp ? 1 : 0;
        end else if (drp) begin
            m_ovf = 1'b1;
            if (m_dc < DMAX) m_dc++;
        end
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int wcnt;
        bus.flush          = 1'b0;
        bus.write_enable   = 1'b0;
        bus.write_data     = '0;
        bus.read_enable    = 1'b0;
        bus.clear_overflow = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #3 reset = 1'b1;

        // Fill, overflow, drain, clear.
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle();

        // Simultaneous read and write at full.
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle();

        // Read+write at empty, then 20 words through a shallow level across wrap.
        step(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        wcnt = 0;
        for (int i = 0; i < 40; i++) begin
            bit we;
            bit re;
            we = (wcnt < 20) && (mq.size() < 3);
            re = (mq.size() > 1) || (mq.size() == 1 && ($urandom_range(0, 1) == 1));
            step(we, DW'($urandom), re, 1'b0, 1'b0);
            if (we) wcnt++;
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Drop-count saturation, then clear coinciding with a drop.
        for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        idle();

        // Flush at level 5 keeps read_data and overflow.
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle();
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        idle();
        step(1'b1, 8'h78, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle();

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            bit fl;
            bit clr;
            fl  = ($urandom_range(0, 99) < 3);
            clr = !fl && ($urandom_range(0, 99) < 5);
            step(($urandom_range(0, 99) < 60), DW'($urandom),
                 ($urandom_range(0, 99) < 50), fl, clr);
        end

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom), (i % 3 == 2), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        @(posedge clock);
        #3;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_rst level", int'(bus.level), 0);
        chk("async_rst empty", int'(bus.empty), 1);
        chk("async_rst full", int'(bus.full), 0);
        chk("async_rst almost_full", int'(bus.almost_full), 0);
        chk("async_rst read_valid", int'(bus.read_valid), 0);
        chk("async_rst read_data", int'(bus.read_data), 0);
        chk("async_rst overflow", int'(bus.overflow), 0);
        chk("async_rst drop_count", int'(bus.drop_count), 0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle();
        idle();
        @(posedge clock);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ringbuffer_counted.md
Name: ringbuffer_counted

Overview:
Parametrised successor to the capture ring buffer. It is a single-clock FIFO between the LPC frame decoder (writer) and the UART/readout path (reader). It stores all 2^AW entries using an occupancy counter, and registers its read data with a valid strobe. It drops writes when full, counting them in a saturating drop counter with a sticky overflow flag, and reports fill level and almost-full.

Parameters:
AW, 8, address width; depth = 2^AW entries (AW >= 2)
DW, 48, data word width
CW, 16, drop counter width
AFULL_TH, 2^AW-4, almost_full asserts when level >= AFULL_TH (1..2^AW)

Ports:
clock  in  1  sole clock; all state updates on falling edge, as in the rest of the capture path
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous discard of all stored entries
write_enable  in  1  write request, one word per cycle
write_data  in  DW  word to store
read_enable  in  1  read request, one word per cycle
read_data  out  DW  registered output word
read_valid  out  1  read_data holds a newly popped word this cycle
empty  out  1  level == 0
full  out  1  level == 2^AW
almost_full  out  1  level >= AFULL_TH
level  out  AW+1  number of stored entries, 0..2^AW
overflow  out  1  sticky: at least one write dropped since last clear
drop_count  out  CW  saturating count of dropped writes
clear_overflow  in  1  clears overflow and drop_count

Behaviour:
- Reset (reset=0, asynchronous): write/read pointers=0, level=0, read_data=0, read_valid=0, overflow=0, drop_count=0. Outputs follow immediately: empty=1, full=0, almost_full=0.
- Pointers are AW bits and wrap naturally from 2^AW-1 to 0. Full and empty come from level, never from pointer compare, so all 2^AW slots are usable.
- Write accepted when write_enable=1 and (full=0, or read accepted in the same edge). The word is stored at write pointer, which then increments.
- Read accepted when read_enable=1 and empty=0. The word at read pointer is registered into read_data at that edge and read_valid=1 for exactly the following cycle; the read pointer increments.
- Read latency is 1 cycle. With no accepted read, read_valid=0 and read_data holds its last value.
- Level update per edge: +1 write only; -1 read only; unchanged for both or neither.
- Full with simultaneous read and write: both are accepted, level stays 2^AW, and no drop is counted.
- Empty with simultaneous read and write: the write is accepted and the read is ignored (no fall-through). level=1, read_valid=0 next cycle.
- Dropped write: write_enable=1, full=1, and no accepted read. Data is discarded, overflow is set, and drop_count increments, saturating at 2^CW-1.
- clear_overflow=1: overflow and drop_count go to 0. If a drop occurs on the same edge, the result is overflow=1 and drop_count=1.
- flush=1 takes priority over read and write on that edge. Pointers and level go to 0 and read_valid goes to 0. read_data, overflow and drop_count are preserved. A write with flush is neither stored nor counted as a drop.
- empty, full, almost_full and level are combinational from the level register. overflow and drop_count are registered.
- Memory is an inferred array with a registered read port, suitable for iCE40 block RAM. There is no reset on the array contents.

Test Plan:
- Fill/drain, AW=3, DW=8: write 0x01..0x08 -> full=1, level=8, almost_full=1 from level 4 (AFULL_TH=4). Read 8 times -> read_data 0x01..0x08 in order, each with read_valid one cycle after read_enable. Finally empty=1.
- Overflow: from full, write 0xAA, 0xBB with no read -> overflow=1, drop_count=2, level=8. Drain yields 0x01..0x08 only. clear_overflow -> overflow=0, drop_count=0.
- Simultaneous at full: level=8, assert read and write (0x55) together -> read_data=oldest word, level=8, drop_count unchanged. 0x55 emerges last on drain.
- Simultaneous at empty plus wrap: cycle 20 words through with level kept at 1–3 -> no loss or reorder across pointer wrap. A read+write at level 0 gives read_valid=0 and level=1.
- Saturation, CW=4: 20 drops at full -> drop_count stops at 15. A clear on the same edge as a drop gives drop_count=1.
- Flush and reset: with level=5, pulse flush -> level=0, empty=1, read_data unchanged, overflow kept. Assert reset mid-burst, asynchronous to clock -> all outputs take reset values before the next clock edge.
